mac_operand_feeder: RTL and testbench
=====================================

Name: mac_operand_feeder

Overview:
- Upstream stage of mac_int_fsm.
- Buffers signed 8-bit operand pairs from a streaming source in a small FIFO and issues them to the MAC one at a time using the MAC's valid/done protocol.
- Holds each operand pair stable for the full MAC operation.
- Groups elements into vectors delimited by a `last` flag and reports each vector's dot product as the 32-bit difference between the MAC running accumulator at vector end and at vector start, with a sticky overflow flag.

Parameters:
- DEPTH, 4, operand FIFO entries; power of two, ≥2.
- LEN_W, 8, width of the per-vector element counter; saturates at 2^LEN_W-1.

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- in_valid  in  1  operand pair offered
- in_ready  out  1  FIFO not full
- in_a  in  8  signed operand A
- in_b  in  8  signed operand B
- in_last  in  1  pair is last element of the vector
- mac_valid  out  1  one-cycle issue pulse to the MAC
- mac_a  out  8  operand A to the MAC, held stable
- mac_b  out  8  operand B to the MAC, held stable
- mac_done  in  1  MAC done pulse
- mac_overflow  in  1  MAC overflow, meaningful during mac_done
- mac_y  in  32  MAC accumulator output
- res_valid  out  1  vector result available
- res_ready  in  1  consumer accepts result
- res_y  out  32  signed vector dot product
- res_ovf  out  1  any element of the vector overflowed
- res_len  out  LEN_W  element count of the vector
- busy  out  1  FIFO non-empty or state ≠ IDLE

Behaviour:
- Reset:
  - All outputs 0; FIFO emptied (in_ready=1); state IDLE.
  - Element counter, base register, sticky ovf cleared.
  - Reset mid-operation aborts everything; the MAC shares the same reset.
- FIFO:
  - Width 17 bits ({last,a,b}), registered pointers with a wrap bit.
  - Push when in_valid && in_ready.
  - Pop only on the ISSUE state entry edge.
  - Simultaneous push and pop when full is not allowed: in_ready is full-based, not pop-aware.
- FSM states: IDLE, ISSUE, WAIT, RESULT.
  - IDLE: if FIFO non-empty, pop into the operand registers {op_a, op_b, op_last}, then go to ISSUE.
  - ISSUE: mac_valid=1 for exactly one cycle. If the element counter is 0, capture base <= mac_y; the MAC is idle, so y is stable. Go to WAIT.
  - WAIT:
    - On mac_done: counter+1 (saturating); ovf_sticky |= mac_overflow.
    - If op_last, go to RESULT.
    - Otherwise, if the FIFO is non-empty, pop and go to ISSUE; else go to IDLE.
  - RESULT:
    - Entered the cycle after done; mac_y is already updated.
    - If res_valid=0: load res_y <= mac_y - base (32-bit wrap), res_ovf <= ovf_sticky, res_len <= counter. Set res_valid, clear counter and ovf_sticky, go to IDLE.
    - If res_valid=1 and !res_ready: stay in RESULT (stall).
- Result handshake: res_valid stays high until the cycle with res_ready=1, then clears next edge. Result fields are stable while valid.
- mac_a/mac_b mirror the operand registers; they change only on pop and are held from ISSUE through the done cycle.
- Timing:
  - Push accepted at edge E (FIFO empty, IDLE): mac_valid is high in cycle E+2.
  - Issue cadence is 4 cycles per element: ISSUE T, MAC done at T+3, next ISSUE at T+4.
  - Last element issued at T: RESULT at T+4, res_valid high from T+5.
- A mac_done arriving outside WAIT is ignored.
- A zero-length vector is impossible: a vector ends only on an element flagged last.

Decomposition:
- Package mac_pkg: DATA_W=8, ACC_W=32, the feeder state enum type, and the FIFO entry struct {last,a,b}.
- One sub-module, mac_operand_fifo (parameter DEPTH, synchronous FIFO with full/empty).
- The FSM, base/sticky logic, and result register live in the top.

Test Plan:
- Reset then idle: res_valid=0, mac_valid=0, in_ready=1, busy=0.
- Push (3,4),(−2,5),(7,−1,last) back-to-back with a MAC attached and res_ready=1 → three mac_valid pulses 4 cycles apart; res_y=−5, res_len=3, res_ovf=0.
- Two vectors: (10,10,last) then (−1,1,last) → res_y=100, then res_y=−1; the second result is independent of the first via the base subtraction.
- Hold res_ready=0 after a vector, push 5 more pairs → FSM stalls in RESULT, FIFO fills, in_ready=0 after DEPTH entries; release → result clears and issuing resumes with no loss.
- Preload the MAC accumulator near 0x7FFFFFFF via repeated (127,127), then issue more (127,127) → mac_overflow is seen at done; res_ovf=1 for that vector, and res_ovf=0 for the next clean vector.
- Assert reset during WAIT → all outputs 0 immediately; FIFO empty; the next vector after reset computes correctly.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared types and widths for the MAC operand feeder slice.
package mac_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ACC_W  = 32;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StResult
    } feeder_state_e;

    typedef struct packed {
        logic              last;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } fifo_entry_t;

endpackage

// File: rtl/mac_operand_feeder_if.sv
// Operand stream, MAC issue/done and result handshake bundle.
// slave is the feeder's view; master is the surrounding environment's view.
interface mac_operand_feeder_if
    import mac_pkg::*;
#(
    parameter int unsigned LEN_W = 8
);

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_a;
    logic [DATA_W-1:0] in_b;
    logic              in_last;

    logic              mac_valid;
    logic [DATA_W-1:0] mac_a;
    logic [DATA_W-1:0] mac_b;
    logic              mac_done;
    logic              mac_overflow;
    logic [ACC_W-1:0]  mac_y;

    logic              res_valid;
    logic              res_ready;
    logic [ACC_W-1:0]  res_y;
    logic              res_ovf;
    logic [LEN_W-1:0]  res_len;

    logic              busy;

    modport slave (
        input  in_valid, in_a, in_b, in_last,
        output in_ready,
        output mac_valid, mac_a, mac_b,
        input  mac_done, mac_overflow, mac_y,
        output res_valid, res_y, res_ovf, res_len,
        input  res_ready,
        output busy
    );

    modport master (
        output in_valid, in_a, in_b, in_last,
        input  in_ready,
        input  mac_valid, mac_a, mac_b,
        output mac_done, mac_overflow, mac_y,
        input  res_valid, res_y, res_ovf, res_len,
        output res_ready,
        input  busy
    );

endinterface

// File: rtl/mac_operand_fifo.sv
// Synchronous operand FIFO; pointers carry a wrap bit to tell full from empty.
module mac_operand_fifo
    import mac_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_push,
    input  fifo_entry_t i_wdata,
    input  logic        i_pop,
    output fifo_entry_t o_rdata,
    output logic        o_empty,
    output logic        o_full
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PtrOne = 1;

    fifo_entry_t r_mem [DEPTH];
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic        w_do_push;
    logic        w_do_pop;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_rdata   = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PtrOne;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PtrOne;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
    end

endmodule

// File: rtl/mac_operand_feeder.sv
// Feeds buffered operand pairs to the MAC one at a time and reports per-vector
// dot products as the accumulator delta between vector start and end.
module mac_operand_feeder
    import mac_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned LEN_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    mac_operand_feeder_if.slave  bus
);

    localparam logic [LEN_W-1:0] CntOne = 1;
    localparam logic [LEN_W-1:0] CntMax = '1;

    feeder_state_e     r_state;
    fifo_entry_t       w_head;
    fifo_entry_t       w_wdata;
    logic              w_empty;
    logic              w_full;
    logic              w_push;
    logic              w_pop;
    logic [DATA_W-1:0] r_op_a;
    logic [DATA_W-1:0] r_op_b;
    logic              r_op_last;
    logic              r_mac_valid;
    logic [ACC_W-1:0]  r_base;
    logic              r_ovf_sticky;
    logic [LEN_W-1:0]  r_count;
    logic              r_res_valid;
    logic [ACC_W-1:0]  r_res_y;
    logic              r_res_ovf;
    logic [LEN_W-1:0]  r_res_len;

    assign w_wdata = '{last: bus.in_last, a: bus.in_a, b: bus.in_b};
    assign w_push  = bus.in_valid && !w_full;

    // A pop always coincides with the transition into StIssue.
    always_comb begin
        w_pop = 1'b0;
        if (!w_empty) begin
            if (r_state == StIdle) begin
                w_pop = 1'b1;
            end else if (r_state == StWait && bus.mac_done && !r_op_last) begin
                w_pop = 1'b1;
            end
        end
    end

    mac_operand_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_wdata (w_wdata),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= StIdle;
            r_op_a       <= '0;
            r_op_b       <= '0;
            r_op_last    <= 1'b0;
            r_mac_valid  <= 1'b0;
            r_base       <= '0;
            r_ovf_sticky <= 1'b0;
            r_count      <= '0;
            r_res_valid  <= 1'b0;
            r_res_y      <= '0;
            r_res_ovf    <= 1'b0;
            r_res_len    <= '0;
        end else begin
            r_mac_valid <= 1'b0;
            if (r_res_valid && bus.res_ready) r_res_valid <= 1'b0;
            if (w_pop) begin
                r_op_a      <= w_head.a;
                r_op_b      <= w_head.b;
                r_op_last   <= w_head.last;
                r_mac_valid <= 1'b1;
            end
            unique case (r_state)
                StIdle: begin
                    if (w_pop) r_state <= StIssue;
                end
                StIssue: begin
                    // The MAC is idle here, so mac_y is the settled vector start value.
                    if (r_count == '0) r_base <= bus.mac_y;
                    r_state <= StWait;
                end
                StWait: begin
                    if (bus.mac_done) begin
                        if (r_count != CntMax) r_count <= r_count + CntOne;
                        r_ovf_sticky <= r_ovf_sticky | bus.mac_overflow;
                        if (r_op_last)  r_state <= StResult;
                        else if (w_pop) r_state <= StIssue;
                        else            r_state <= StIdle;
                    end
                end
                StResult: begin
                    if (!r_res_valid) begin
                        r_res_y      <= bus.mac_y - r_base;
                        r_res_ovf    <= r_ovf_sticky;
                        r_res_len    <= r_count;
                        r_res_valid  <= 1'b1;
                        r_count      <= '0;
                        r_ovf_sticky <= 1'b0;
                        r_state      <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign bus.in_ready  = !w_full;
    assign bus.mac_valid = r_mac_valid;
    assign bus.mac_a     = r_op_a;
    assign bus.mac_b     = r_op_b;
    assign bus.res_valid = r_res_valid;
    assign bus.res_y     = r_res_y;
    assign bus.res_ovf   = r_res_ovf;
    assign bus.res_len   = r_res_len;
    assign bus.busy      = !w_empty || (r_state != StIdle);

endmodule

// File: tb/tb_mac_operand_feeder.sv
// Directed-plus-random bench: a 3-cycle MAC responder and a per-vector
// arithmetic reference model (sum of products, signed 32-bit overflow).
module tb_mac_operand_feeder;
    import mac_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned LEN_W = 8;
    localparam int          LEN_MAX = (1 << LEN_W) - 1;

    typedef struct {
        logic [31:0] y;
        logic        ovf;
        int          len;
    } res_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mac_operand_feeder_if #(.LEN_W(LEN_W)) bus ();

    mac_operand_feeder #(
        .DEPTH (DEPTH),
        .LEN_W (LEN_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int cycle    = 0;
    int push_cycle;

    res_t exp_q[$];
    res_t got_q[$];
    int   issue_q[$];

    logic signed [31:0] ref_acc;
    logic [31:0]        cur_sum;
    logic               cur_ovf;
    int                 cur_len;

    // MAC responder: done three cycles after the issue cycle, y updated with done.
    logic signed [31:0] mac_acc;
    logic signed [7:0]  mac_la;
    logic signed [7:0]  mac_lb;
    int                 mac_cnt;
    logic               preload_req;
    logic signed [31:0] preload_val;

    function automatic logic signed [31:0] add_wrap(input logic signed [31:0] acc,
                                                    input logic signed [7:0] a,
                                                    input logic signed [7:0] b);
        longint s;
        s = longint'(acc) + longint'(a) * longint'(b);
        return s[31:0];
    endfunction

    function automatic logic add_ovf(input logic signed [31:0] acc,
                                     input logic signed [7:0] a,
                                     input logic signed [7:0] b);
        longint             s;
        logic signed [31:0] w;
        s = longint'(acc) + longint'(a) * longint'(b);
        w = s[31:0];
        return longint'(w) != s;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mac_acc          <= '0;
            mac_cnt          <= 0;
            mac_la           <= '0;
            mac_lb           <= '0;
            bus.mac_done     <= 1'b0;
            bus.mac_overflow <= 1'b0;
        end else begin
            bus.mac_done     <= 1'b0;
            bus.mac_overflow <= 1'b0;
            if (preload_req) mac_acc <= preload_val;
            if (bus.mac_valid) begin
                mac_la  <= bus.mac_a;
                mac_lb  <= bus.mac_b;
                mac_cnt <= 2;
            end else if (mac_cnt > 0) begin
                mac_cnt <= mac_cnt - 1;
                if (mac_cnt == 1) begin
                    mac_acc          <= add_wrap(mac_acc, mac_la, mac_lb);
                    bus.mac_overflow <= add_ovf(mac_acc, mac_la, mac_lb);
                    bus.mac_done     <= 1'b1;
                end
            end
        end
    end
    assign bus.mac_y = mac_acc;

    always @(posedge clk) cycle <= cycle + 1;

    always @(negedge clk) begin
        if (!reset && bus.res_valid && bus.res_ready)
            got_q.push_back('{y: bus.res_y, ovf: bus.res_ovf, len: int'(bus.res_len)});
        if (!reset && bus.mac_valid) issue_q.push_back(cycle);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_ready(input logic v);
        @(posedge clk);
        #1 bus.res_ready = v;
    endtask

    task automatic push(input logic signed [7:0] a, input logic signed [7:0] b,
                        input logic last);
        int k = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_last  = last;
        while (!bus.in_ready && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (!bus.in_ready) chk("push_timeout", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        push_cycle = cycle;
        cur_sum = cur_sum + 32'(int'(a) * int'(b));
        cur_ovf = cur_ovf | add_ovf(ref_acc, a, b);
        ref_acc = add_wrap(ref_acc, a, b);
        if (cur_len < LEN_MAX) cur_len++;
        if (last) begin
            exp_q.push_back('{y: cur_sum, ovf: cur_ovf, len: cur_len});
            cur_sum = '0;
            cur_ovf = 1'b0;
            cur_len = 0;
        end
    endtask

    task automatic results(input string tag, input int budget);
        int   k = 0;
        res_t e;
        res_t g;
        while (got_q.size() < exp_q.size() && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            chk({tag, "_y"}, g.y, e.y);
            chk({tag, "_ovf"}, 32'(g.ovf), 32'(e.ovf));
            chk({tag, "_len"}, 32'(g.len), 32'(e.len));
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while ((bus.busy || bus.res_valid) && k < 3000) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        int t0;
        int k;
        int n;
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_a     = '0;
        bus.in_b     = '0;
        bus.in_last  = 1'b0;
        bus.res_ready = 1'b0;
        preload_req  = 1'b0;
        preload_val  = '0;
        ref_acc      = '0;
        cur_sum      = '0;
        cur_ovf      = 1'b0;
        cur_len      = 0;
        repeat (3) @(negedge clk);
        chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
        chk("rst_mac_valid", 32'(bus.mac_valid), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_res_y", bus.res_y, 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_mac_valid", 32'(bus.mac_valid), 32'd0);
        chk("idle_busy", 32'(bus.busy), 32'd0);

        // Three-element vector: -5, issued at a 4-cycle cadence.
        set_ready(1'b1);
        issue_q.delete();
        push(8'sd3, 8'sd4, 1'b0);
        t0 = push_cycle;
        push(-8'sd2, 8'sd5, 1'b0);
        push(8'sd7, -8'sd1, 1'b1);
        results("vec1", 200);
        chk("vec1_issues", 32'(issue_q.size()), 32'd3);
        if (issue_q.size() >= 3) begin
            // Sampled in the cycle that ends at edge E+2.
            chk("vec1_first_issue", 32'(issue_q[0]), 32'(t0 + 1));
            chk("vec1_gap1", 32'(issue_q[1] - issue_q[0]), 32'd4);
            chk("vec1_gap2", 32'(issue_q[2] - issue_q[1]), 32'd4);
        end

        // Back-to-back one-element vectors; base subtraction isolates them.
        push(8'sd10, 8'sd10, 1'b1);
        push(-8'sd1, 8'sd1, 1'b1);
        results("vec2", 200);

        // Stall the consumer: second vector parks in RESULT and the FIFO fills.
        wait_idle("idle_pre_stall");
        set_ready(1'b0);
        push(8'($urandom), 8'($urandom), 1'b0);
        push(8'($urandom), 8'($urandom), 1'b1);
        push(8'($urandom), 8'($urandom), 1'b1);
        for (int i = 0; i < 4; i++) push(8'($urandom), 8'($urandom), i == 3);
        repeat (12) @(negedge clk);
        chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
        chk("stall_res_valid", 32'(bus.res_valid), 32'd1);
        chk("stall_busy", 32'(bus.busy), 32'd1);
        chk("stall_res_y", bus.res_y, exp_q[0].y);
        chk("stall_no_accept", 32'(got_q.size()), 32'd0);
        set_ready(1'b1);
        results("stall", 400);

        // Random vectors of 1..5 elements.
        for (int v = 0; v < 6; v++) begin
            n = int'($urandom_range(1, 5));
            for (int i = 0; i < n; i++) push(8'($urandom), 8'($urandom), i == n - 1);
        end
        results("rand", 1000);

        // Element counter saturates; the sum itself stays exact.
        for (int i = 0; i < LEN_MAX + 2; i++) push(8'sd1, 8'sd1, i == LEN_MAX + 1);
        results("sat", 2000);

        // Accumulator preloaded near the positive limit, then pushed over it.
        wait_idle("idle_pre_ovf");
        @(posedge clk);
        #1 preload_val = 32'sh7FFF_C000;
        preload_req = 1'b1;
        @(posedge clk);
        #1 preload_req = 1'b0;
        ref_acc = 32'sh7FFF_C000;
        push(8'sd127, 8'sd127, 1'b0);
        push(8'sd127, 8'sd127, 1'b1);
        push(8'sd1, 8'sd1, 1'b1);
        results("ovf", 300);

        // Reset while the MAC operation is outstanding.
        wait_idle("idle_pre_reset");
        issue_q.delete();
        push(8'sd5, 8'sd5, 1'b0);
        push(8'sd6, 8'sd6, 1'b1);
        k = 0;
        while (issue_q.size() == 0 && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("reset_issue_seen", 32'(issue_q.size() > 0), 32'd1);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("midrst_mac_valid", 32'(bus.mac_valid), 32'd0);
        chk("midrst_res_valid", 32'(bus.res_valid), 32'd0);
        chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_mac_a", 32'(bus.mac_a), 32'd0);
        exp_q.delete();
        got_q.delete();
        ref_acc = '0;
        cur_sum = '0;
        cur_ovf = 1'b0;
        cur_len = 0;
        @(negedge clk);
        reset = 1'b0;
        push(-8'sd3, 8'sd9, 1'b0);
        push(8'sd4, 8'sd4, 1'b1);
        results("post_reset", 200);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

endmodule
